// File: rtl/if_stage_sram.sv
// Instruction-fetch stage: PC generation, single-outstanding SRAM-like fetch,
// branch redirect with wrong-path squashing, and a one-entry skid buffer toward decode.
module if_stage_sram #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic [32:0] br_bus,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);
    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_req_pc, r_out_pc, r_redir_tgt, r_hold_addr;
    logic        r_outstanding, r_discard, r_redir_pend;
    logic        r_hold_redir, r_hold_stale;
    logic        r_fs_valid, r_buf_valid;
    logic [31:0] r_fs_inst, r_fs_pc, r_buf_inst, r_buf_pc;

    logic        w_br_taken, w_resp, w_fill_buf, w_issue_ok, w_accept, w_out_nxt;
    logic        w_req, w_addr_redir, w_stale;
    logic [31:0] w_br_target, w_addr_sel, w_addr;

    assign w_br_taken  = br_bus[32];
    assign w_br_target = br_bus[31:0];
    assign w_addr_sel  = r_redir_pend ? r_redir_tgt : r_req_pc;

    // Response that survives squashing and is handed to the output slot or buffer.
    assign w_resp      = inst_sram_data_ok && !r_discard && !w_br_taken;
    // A response parking in the buffer this cycle must also block a new issue,
    // otherwise the next response could arrive with the buffer still full.
    assign w_fill_buf  = w_resp && r_fs_valid && !ds_allowin;
    assign w_issue_ok  = !r_buf_valid && (!r_outstanding || inst_sram_data_ok) && !w_fill_buf;

    always_comb begin
        w_state_nxt  = r_state;
        w_req        = 1'b0;
        w_addr       = w_addr_sel;
        w_addr_redir = r_redir_pend;
        w_stale      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_issue_ok) begin
                    w_req = 1'b1;
                    if (!inst_sram_addr_ok) w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                w_req        = 1'b1;
                w_addr       = r_hold_addr;
                w_addr_redir = r_hold_redir && !r_hold_stale;
                w_stale      = r_hold_stale;
                if (inst_sram_addr_ok) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign inst_sram_req   = w_req && !reset;
    assign inst_sram_addr  = w_addr;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_wstrb = 4'd0;
    assign inst_sram_wdata = 32'd0;
    assign w_accept        = inst_sram_req && inst_sram_addr_ok;
    assign w_out_nxt       = w_accept || (r_outstanding && !inst_sram_data_ok);

    assign fs_to_ds_valid  = r_fs_valid;
    assign fs_to_ds_bus    = {r_fs_inst, r_fs_pc};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_req_pc <= RESET_PC;
            r_out_pc <= 32'd0;
            r_redir_tgt <= 32'd0;
            r_hold_addr <= 32'd0;
            r_outstanding <= 1'b0;
            r_discard <= 1'b0;
            r_redir_pend <= 1'b0;
            r_hold_redir <= 1'b0;
            r_hold_stale <= 1'b0;
            r_fs_valid <= 1'b0;
            r_fs_inst <= 32'd0;
            r_fs_pc <= 32'd0;
            r_buf_valid <= 1'b0;
            r_buf_inst <= 32'd0;
            r_buf_pc <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            // Freeze the address of an unaccepted request; a branch seen while it
            // waits marks it stale so its data is dropped once it completes.
            if (r_state == S_IDLE && w_req && !inst_sram_addr_ok) begin
                r_hold_addr  <= w_addr_sel;
                r_hold_redir <= r_redir_pend;
                r_hold_stale <= w_br_taken;
            end else if (r_state == S_REQ && !inst_sram_addr_ok && w_br_taken) begin
                r_hold_stale <= 1'b1;
            end

            if (w_accept) begin
                r_out_pc <= w_addr;
                r_req_pc <= w_addr + 32'd4;
            end

            if (w_br_taken) begin
                r_redir_pend <= 1'b1;
                r_redir_tgt  <= w_br_target;
            end else if (w_accept && w_addr_redir) begin
                r_redir_pend <= 1'b0;
            end

            r_outstanding <= w_out_nxt;

            if ((w_br_taken && w_out_nxt) || (w_accept && w_stale))
                r_discard <= 1'b1;
            else if (inst_sram_data_ok)
                r_discard <= 1'b0;

            if (w_br_taken) begin
                r_fs_valid  <= 1'b0;
                r_buf_valid <= 1'b0;
            end else if (!r_fs_valid || ds_allowin) begin
                if (r_buf_valid) begin
                    r_fs_valid  <= 1'b1;
                    r_fs_inst   <= r_buf_inst;
                    r_fs_pc     <= r_buf_pc;
                    r_buf_valid <= 1'b0;
                end else if (w_resp) begin
                    r_fs_valid <= 1'b1;
                    r_fs_inst  <= inst_sram_rdata;
                    r_fs_pc    <= r_out_pc;
                end else begin
                    r_fs_valid <= 1'b0;
                end
            end else if (w_resp) begin
                r_buf_valid <= 1'b1;
                r_buf_inst  <= inst_sram_rdata;
                r_buf_pc    <= r_out_pc;
            end
        end
    end
endmodule

// File: tb/tb_if_stage_sram.sv
// Scoreboard bench for if_stage_sram: directed phases with an SRAM model of
// programmable latency; a negedge monitor checks every delivered {inst, pc}.
module tb_if_stage_sram;
    localparam logic [31:0] X  = 32'h1c000000;
    localparam logic [31:0] T  = 32'h1c000100;
    localparam logic [31:0] T2 = 32'h1c000200;

    logic        clk = 1'b0, reset = 1'b1, ds_allowin = 1'b0;
    logic [32:0] br_bus = 33'd0;
    logic        fs_to_ds_valid, inst_sram_req, inst_sram_wr;
    logic [63:0] fs_to_ds_bus;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_wdata, inst_sram_addr;
    logic        addr_ok = 1'b1, data_ok = 1'b0;
    logic [31:0] rdata = 32'd0;

    if_stage_sram dut (
        .clk(clk), .reset(reset), .ds_allowin(ds_allowin), .br_bus(br_bus),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_wdata(inst_sram_wdata), .inst_sram_addr(inst_sram_addr),
        .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok),
        .inst_sram_rdata(rdata)
    );

    always #5 clk = ~clk;

    int          errors = 0, checks = 0, n_deliv = 0, cyc = 0, lat = 1;
    logic [63:0] sb[$];

    function automatic logic [31:0] mem_f(logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push(logic [31:0] pc);
        sb.push_back({mem_f(pc), pc});
    endtask

    // SRAM model: data_ok comes 'lat' cycles after the accepting edge.
    logic        m_acc, m_rst, m_busy = 1'b0;
    logic [31:0] m_a, m_pend;
    int          m_cnt = 0;
    always begin
        @(negedge clk);
        m_acc = inst_sram_req && addr_ok;
        m_a   = inst_sram_addr;
        m_rst = reset;
        @(posedge clk);
        #1;
        if (data_ok) m_busy = 1'b0;
        data_ok = 1'b0;
        rdata   = 32'd0;
        if (m_rst) begin
            m_busy = 1'b0;
        end else begin
            if (m_acc) begin
                m_busy = 1'b1;
                m_cnt  = lat;
                m_pend = m_a;
            end
            if (m_busy) begin
                if (m_cnt <= 1) begin
                    data_ok = 1'b1;
                    rdata   = mem_f(m_pend);
                end else begin
                    m_cnt--;
                end
            end
        end
    end

    // Monitor: every transfer to decode must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [63:0] e;
        if (reset) begin
            cyc = 0;
        end else begin
            cyc++;
            if (fs_to_ds_valid && ds_allowin) begin
                n_deliv++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_delivery: got %h want none", fs_to_ds_bus);
                end else begin
                    e = sb.pop_front();
                    chk("deliver", fs_to_ds_bus, e);
                end
            end
        end
    end

    task automatic go(int k);
        int g = 0;
        while (cyc < k && g < 300) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (g >= 300) chk("go_timeout", 64'(cyc), 64'(k));
    endtask

    // Return just after the edge that starts cycle k, so drives apply to cycle k.
    task automatic drive_for(int k);
        go(k - 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(int n);
        @(posedge clk);
        #1;
        reset = 1'b1; ds_allowin = 1'b0; br_bus = 33'd0; addr_ok = 1'b1;
        sb.delete();
        repeat (n) @(posedge clk);
        #1;
        chk("rst_valid", 64'(fs_to_ds_valid), 64'd0);
        chk("rst_req", 64'(inst_sram_req), 64'd0);
        chk("rst_bus", fs_to_ds_bus, 64'd0);
        reset   = 1'b0;
        n_deliv = 0;
    endtask

    task automatic end_phase(string name, int n);
        @(posedge clk);
        #1;
        ds_allowin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_leftover"}, 64'(sb.size()), 64'd0);
        chk({name, "_count"}, 64'(n_deliv), 64'(n));
    endtask

    initial begin
        // Phase 1: ideal memory, back-to-back delivery, then a 3-cycle decode stall.
        lat = 1;
        do_reset(3);
        chk("const_wr", 64'(inst_sram_wr), 64'd0);
        chk("const_size", 64'(inst_sram_size), 64'd2);
        chk("const_wstrb", 64'(inst_sram_wstrb), 64'd0);
        chk("const_wdata", 64'(inst_sram_wdata), 64'd0);
        ds_allowin = 1'b1;
        for (int i = 0; i < 6; i++) push(X + 32'(4 * i));
        go(1);
        chk("p1_req_c1", 64'(inst_sram_req), 64'd1);
        chk("p1_addr_c1", 64'(inst_sram_addr), 64'(X));
        go(2);
        chk("p1_valid_c2", 64'(fs_to_ds_valid), 64'd0);
        go(3);
        chk("p1_ndeliv_c3", 64'(n_deliv), 64'd1);
        go(5);
        chk("p1_ndeliv_c5", 64'(n_deliv), 64'd3);
        @(posedge clk); #1; ds_allowin = 1'b0;
        for (int k = 6; k <= 8; k++) begin
            go(k);
            chk("p1_stall_req", 64'(inst_sram_req), 64'd0);
        end
        @(posedge clk); #1; ds_allowin = 1'b1;
        go(12);
        end_phase("p1", 6);

        // Phase 2: branch while the request to X+8 is outstanding (latency 3).
        lat = 3;
        do_reset(2);
        ds_allowin = 1'b1;
        push(X); push(X + 32'd4); push(T); push(T + 32'd4);
        drive_for(9);
        br_bus = {1'b1, T};
        drive_for(10);
        br_bus = 33'd0;
        go(10);
        chk("p2_req_tgt", 64'(inst_sram_req), 64'd1);
        chk("p2_addr_tgt", 64'(inst_sram_addr), 64'(T));
        go(17);
        end_phase("p2", 4);

        // Phase 3: addr_ok held low for 4 cycles, branch mid-wait.
        lat = 1;
        do_reset(2);
        ds_allowin = 1'b1;
        addr_ok = 1'b0;
        push(T2);
        go(1);
        chk("p3_addr_c1", 64'(inst_sram_addr), 64'(X));
        drive_for(3);
        br_bus = {1'b1, T2};
        drive_for(4);
        br_bus = 33'd0;
        go(4);
        chk("p3_req_c4", 64'(inst_sram_req), 64'd1);
        chk("p3_addr_c4", 64'(inst_sram_addr), 64'(X));
        @(posedge clk); #1; addr_ok = 1'b1;
        go(5);
        chk("p3_addr_c5", 64'(inst_sram_addr), 64'(X));
        go(6);
        chk("p3_req_c6", 64'(inst_sram_req), 64'd1);
        chk("p3_addr_c6", 64'(inst_sram_addr), 64'(T2));
        go(8);
        end_phase("p3", 1);

        // Phase 4: data_ok 5 cycles after accept; no second request meanwhile.
        lat = 5;
        do_reset(2);
        ds_allowin = 1'b1;
        push(X); push(X + 32'd4); push(X + 32'd8);
        go(1);
        chk("p4_addr_c1", 64'(inst_sram_addr), 64'(X));
        for (int k = 2; k <= 5; k++) begin
            go(k);
            chk("p4_no_req", 64'(inst_sram_req), 64'd0);
        end
        go(6);
        chk("p4_addr_c6", 64'(inst_sram_addr), 64'(X + 32'd4));
        go(11);
        chk("p4_ndeliv_c11", 64'(n_deliv), 64'd1);
        go(17);
        end_phase("p4", 3);

        // Phase 5: reset while a request is outstanding.
        lat = 5;
        do_reset(2);
        ds_allowin = 1'b1;
        go(2);
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk); #1;
        chk("p5_rst_req", 64'(inst_sram_req), 64'd0);
        chk("p5_rst_valid", 64'(fs_to_ds_valid), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        n_deliv = 0;
        push(X);
        go(1);
        chk("p5_req_c1", 64'(inst_sram_req), 64'd1);
        chk("p5_addr_c1", 64'(inst_sram_addr), 64'(X));
        for (int k = 2; k <= 6; k++) begin
            go(k);
            chk("p5_valid_low", 64'(fs_to_ds_valid), 64'd0);
        end
        go(7);
        end_phase("p5", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
